// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one single-port BRAM between loader, fetch and data access
// Fixed priority ld > dm > if with a fetch anti-starvation override; read data is routed back via a tag pipeline.
module bram_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {GNT_NONE, GNT_LD, GNT_IF, GNT_DM} gnt_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_DM} tag_t;

    gnt_t             gnt;
    tag_t             issue_tag;
    tag_t             tag_pipe [RD_LAT];
    logic [CNT_W-1:0] starve_cnt;
    logic             ld_pend;
    logic             if_pend;
    logic             dm_pend;
    logic             if_starved;
    logic             pipe_busy;

    // A requester acked this cycle still holds req; mask it so it is not granted twice.
    assign ld_pend    = ld_req & ~ld_ack;
    assign if_pend    = if_req & ~if_ack;
    assign dm_pend    = dm_req & ~dm_ack;
    assign if_starved = (starve_cnt == CNT_W'(STARVE_MAX));

    always_comb begin
        gnt = GNT_NONE;
        if (ld_pend)
            gnt = GNT_LD;
        else if (if_pend && if_starved)
            gnt = GNT_IF;
        else if (dm_pend)
            gnt = GNT_DM;
        else if (if_pend)
            gnt = GNT_IF;
    end

    // The access on the BRAM this cycle is identified by which ack is high.
    always_comb begin
        issue_tag = TAG_NONE;
        if (if_ack)
            issue_tag = TAG_IF;
        else if (dm_ack && !bram_we)
            issue_tag = TAG_DM;
    end

    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            if (tag_pipe[k] != TAG_NONE)
                pipe_busy = 1'b1;
        end
    end

    assign busy = bram_en | pipe_busy;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ld_ack     <= 1'b0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            ld_ack  <= (gnt == GNT_LD);
            if_ack  <= (gnt == GNT_IF);
            dm_ack  <= (gnt == GNT_DM);
            bram_en <= (gnt != GNT_NONE);
            bram_we <= 1'b0;
            case (gnt)
                GNT_LD: begin
                    bram_we    <= 1'b1;
                    bram_addr  <= ld_addr;
                    bram_wdata <= ld_wdata;
                end
                GNT_IF: begin
                    bram_addr <= if_addr;
                end
                GNT_DM: begin
                    bram_we    <= dm_we;
                    bram_addr  <= dm_addr;
                    bram_wdata <= dm_wdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag leaves the pipe in the cycle bram_rdata is valid; rdata and rvalid register together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < RD_LAT; k++)
                tag_pipe[k] <= TAG_NONE;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int k = 1; k < RD_LAT; k++)
                tag_pipe[k] <= tag_pipe[k-1];
            if_rvalid <= (tag_pipe[RD_LAT-1] == TAG_IF);
            dm_rvalid <= (tag_pipe[RD_LAT-1] == TAG_DM);
            if (tag_pipe[RD_LAT-1] == TAG_IF)
                if_rdata <= bram_rdata;
            if (tag_pipe[RD_LAT-1] == TAG_DM)
                dm_rdata <= bram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (if_pend && gnt != GNT_IF) begin
            if (!if_starved)
                starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - self-checking bench for bram_port_arbiter
module tb_bram_port_arbiter;
    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 32;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 8;

    logic              clk = 1'b0;
    logic              rstn;
    logic              ld_req, ld_ack;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              if_req, if_ack, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we, dm_ack, dm_rvalid;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic              bram_en, bram_we, busy;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata, bram_rdata;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata), .busy(busy)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return (i == 5) ? 32'h2402_000A : 32'hC0DE_0000 + 32'(i);
    endfunction

    // BRAM model: read data valid RD_LAT cycles after the enable cycle, garbage otherwise.
    logic              preload;
    logic [DATA_W-1:0] mem  [16];
    logic [DATA_W-1:0] rd_q [RD_LAT];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (bram_en && bram_we) begin
            mem[bram_addr[3:0]] <= bram_wdata;
        end
        rd_q[0] <= (bram_en && !bram_we) ? mem[bram_addr[3:0]] : 32'hDEAD_BEEF;
        for (int k = 1; k < RD_LAT; k++) rd_q[k] <= rd_q[k-1];
    end
    assign bram_rdata = rd_q[RD_LAT-1];

    // Reference: memory updated in ack order, each read expects its data RD_LAT+1 cycles after ack.
    logic [DATA_W-1:0] ref_mem [16];
    int                exp_if_cyc[$], exp_dm_cyc[$];
    logic [DATA_W-1:0] exp_if_dat[$], exp_dm_dat[$];
    int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
    int n_ld_ack = 0, n_if_ack = 0, n_dm_ack = 0, n_if_rv = 0, n_dm_rv = 0;
    int ld_ack_cyc, if_ack_cyc, dm_ack_cyc, if_rv_cyc, dm_rv_cyc;
    logic ld_ack_q = 0, if_ack_q = 0, dm_ack_q = 0;
    logic drop_ld = 0, drop_if = 0, drop_dm = 0;
    logic [ADDR_W-1:0] last_addr = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        bit hit;
        bit rst_edge;
        rst_edge = !rstn;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_edge) begin
            exp_if_cyc.delete(); exp_if_dat.delete();
            exp_dm_cyc.delete(); exp_dm_dat.delete();
            ld_ack_q = 0; if_ack_q = 0; dm_ack_q = 0; last_addr = '0;
            chk("rst_ctrl", 64'({ld_ack, if_ack, if_rvalid, dm_ack, dm_rvalid, bram_en, bram_we, busy}), 64'(0));
            chk("rst_bram", 64'({bram_addr, bram_wdata}), 64'(0));
            chk("rst_rdata", 64'({if_rdata, dm_rdata}), 64'(0));
            return;
        end
        chk("one_ack", 64'($countones({ld_ack, if_ack, dm_ack}) <= 1), 64'(1));
        chk("en_vs_ack", 64'(bram_en), 64'(ld_ack | if_ack | dm_ack));
        chk("double_grant", 64'((ld_ack & ld_ack_q) | (if_ack & if_ack_q) | (dm_ack & dm_ack_q)), 64'(0));
        chk("ack_no_req", 64'((ld_ack & ~ld_req) | (if_ack & ~if_req) | (dm_ack & ~dm_req)), 64'(0));
        if (!bram_en) begin
            chk("idle_we", 64'(bram_we), 64'(0));
            chk("idle_addr_hold", 64'(bram_addr), 64'(last_addr));
        end
        if (ld_ack) begin
            chk("ld_bram", 64'({bram_we, bram_addr, bram_wdata}), 64'({1'b1, ld_addr, ld_wdata}));
            ref_mem[ld_addr[3:0]] = ld_wdata;
            n_ld_ack++; ld_ack_cyc = cyc; last_addr = ld_addr;
        end
        if (if_ack) begin
            chk("if_bram", 64'({bram_we, bram_addr}), 64'({1'b0, if_addr}));
            exp_if_cyc.push_back(cyc + RD_LAT + 1);
            exp_if_dat.push_back(ref_mem[if_addr[3:0]]);
            n_if_ack++; if_ack_cyc = cyc; last_addr = if_addr;
        end
        if (dm_ack) begin
            chk("dm_bram", 64'({bram_we, bram_addr}), 64'({dm_we, dm_addr}));
            if (dm_we) begin
                chk("dm_wdata", 64'(bram_wdata), 64'(dm_wdata));
                ref_mem[dm_addr[3:0]] = dm_wdata;
            end else begin
                exp_dm_cyc.push_back(cyc + RD_LAT + 1);
                exp_dm_dat.push_back(ref_mem[dm_addr[3:0]]);
            end
            n_dm_ack++; dm_ack_cyc = cyc; last_addr = dm_addr;
        end
        hit = (exp_if_cyc.size() > 0) && (exp_if_cyc[0] == cyc);
        chk("if_rvalid", 64'(if_rvalid), 64'(hit));
        if (hit) begin
            if (if_rvalid) chk("if_rdata", 64'(if_rdata), 64'(exp_if_dat[0]));
            void'(exp_if_cyc.pop_front()); void'(exp_if_dat.pop_front());
        end
        hit = (exp_dm_cyc.size() > 0) && (exp_dm_cyc[0] == cyc);
        chk("dm_rvalid", 64'(dm_rvalid), 64'(hit));
        if (hit) begin
            if (dm_rvalid) chk("dm_rdata", 64'(dm_rdata), 64'(exp_dm_dat[0]));
            void'(exp_dm_cyc.pop_front()); void'(exp_dm_dat.pop_front());
        end
        if (if_rvalid) begin n_if_rv++; if_rv_cyc = cyc; end
        if (dm_rvalid) begin n_dm_rv++; dm_rv_cyc = cyc; end
        chk("busy", 64'(busy), 64'(bram_en || exp_if_cyc.size() > 0 || exp_dm_cyc.size() > 0));
        ld_ack_q = ld_ack; if_ack_q = if_ack; dm_ack_q = dm_ack;
    endtask

    // Requesters release req in the cycle after their ack.
    task automatic step();
        tick();
        if (drop_ld) begin ld_req = 0; drop_ld = 0; end
        if (drop_if) begin if_req = 0; drop_if = 0; end
        if (drop_dm) begin dm_req = 0; drop_dm = 0; end
        if (ld_ack) drop_ld = 1;
        if (if_ack) drop_if = 1;
        if (dm_ack) drop_dm = 1;
    endtask

    function automatic logic port_ack(input int p);
        case (p)
            0:       return ld_ack;
            1:       return if_ack;
            default: return dm_ack;
        endcase
    endfunction

    task automatic wait_ack(input int p);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!port_ack(p) && n < 64);
        chk("ack_timeout", 64'(port_ack(p)), 64'(1));
    endtask

    initial begin
        int c0, first_if, base;
        rstn = 0; preload = 1;
        ld_req = 0; ld_addr = '0; ld_wdata = '0;
        if_req = 0; if_addr = '0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        step(); step();
        preload = 0; rstn = 1;
        step();

        // Loader burst
        for (int i = 0; i < 4; i++) begin
            ld_req = 1; ld_addr = ADDR_W'(i); ld_wdata = 32'hA0 + 32'(i);
            wait_ack(0);
            step();
        end
        chk("ld_burst_acks", 64'(n_ld_ack), 64'(4));
        chk("ld_burst_others", 64'(n_if_ack + n_dm_ack), 64'(0));

        // Single fetch latency
        repeat (3) step();
        c0 = cyc;
        if_req = 1; if_addr = ADDR_W'(5);
        wait_ack(1);
        chk("if_ack_lat", 64'(if_ack_cyc - c0), 64'(1));
        repeat (5) step();
        chk("if_rv_lat", 64'(if_rv_cyc - c0), 64'(4));
        chk("if_rdata_5", 64'(if_rdata), 64'(32'h2402_000A));

        // Three-way contention
        repeat (3) step();
        c0 = cyc;
        ld_req = 1; ld_addr = ADDR_W'(12); ld_wdata = 32'h55AA_55AA;
        dm_req = 1; dm_we = 0; dm_addr = ADDR_W'(7);
        if_req = 1; if_addr = ADDR_W'(3);
        repeat (7) step();
        chk("cont_ld", 64'(ld_ack_cyc - c0), 64'(1));
        chk("cont_dm", 64'(dm_ack_cyc - c0), 64'(2));
        chk("cont_if", 64'(if_ack_cyc - c0), 64'(3));
        chk("cont_dm_rv", 64'(dm_rv_cyc - c0), 64'(5));
        chk("cont_if_rv", 64'(if_rv_cyc - c0), 64'(6));

        // Starvation: loader and data keep the port saturated
        repeat (3) step();
        c0 = cyc; first_if = -1;
        if_req = 1; if_addr = ADDR_W'(2);
        for (int t = 0; t < 20; t++) begin
            if (!ld_req) begin
                ld_req = 1; ld_addr = ADDR_W'($urandom_range(10, 15)); ld_wdata = $urandom;
            end
            if (!dm_req) begin
                dm_req = 1; dm_we = 0; dm_addr = ADDR_W'($urandom_range(0, 15));
            end
            step();
            if (if_ack && first_if < 0) first_if = cyc - c0;
        end
        chk("starve_bound", 64'(first_if > 0 && first_if <= STARVE_MAX + 2), 64'(1));
        repeat (8) step();
        chk("starve_cnt_clear", 64'(dut.starve_cnt), 64'(0));

        // Store then load
        dm_req = 1; dm_we = 1; dm_addr = ADDR_W'(9); dm_wdata = 32'h1234_5678;
        wait_ack(2);
        step();
        base = n_dm_rv;
        dm_req = 1; dm_we = 0; dm_addr = ADDR_W'(9);
        wait_ack(2);
        repeat (5) step();
        chk("st_ld_count", 64'(n_dm_rv - base), 64'(1));
        chk("st_ld_data", 64'(dm_rdata), 64'(32'h1234_5678));

        // Reset while a fetch is in flight
        if_req = 1; if_addr = ADDR_W'(5);
        wait_ack(1);
        base = n_if_rv;
        step();
        rstn = 0;
        step(); step();
        rstn = 1;
        step();
        chk("post_rst_busy", 64'(busy), 64'(0));
        chk("post_rst_ack", 64'({ld_ack, if_ack, dm_ack}), 64'(0));
        repeat (6) step();
        chk("rst_no_rvalid", 64'(n_if_rv - base), 64'(0));

        // Random traffic against the reference
        for (int t = 0; t < 400; t++) begin
            if (!ld_req && $urandom_range(0, 7) == 0) begin
                ld_req = 1; ld_addr = ADDR_W'($urandom_range(0, 15)); ld_wdata = $urandom;
            end
            if (!if_req && $urandom_range(0, 1) == 0) begin
                if_req = 1; if_addr = ADDR_W'($urandom_range(0, 15));
            end
            if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = ADDR_W'($urandom_range(0, 15)); dm_wdata = $urandom;
            end
            step();
        end
        repeat (64) step();
        chk("drain_reqs", 64'({ld_req, if_req, dm_req}), 64'(0));
        chk("drain_busy", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port instruction/data BRAM between three requesters: the UART program loader (LOAD mode), instruction fetch (FETCH stage), and execute-stage load/store.
- Provides fixed priority with an anti-starvation override for fetch.
- Issues at most one BRAM access per cycle and tracks in-flight reads through the BRAM read latency, routing returned data to the originating requester.
- Sits between the fetch/execute/loader blocks and the BRAM instance inside top.

Parameters:
ADDR_W, 15, word address width (INST_SIZE/BRAM_SIZE-sized memories)
DATA_W, 32, data width
RD_LAT, 2, BRAM read latency in cycles (legal 1..4)
STARVE_MAX, 8, pending-cycle count after which fetch outranks data access

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
ld_req  in  1  loader write request
ld_addr  in  ADDR_W  loader word address
ld_wdata  in  DATA_W  loader write data
ld_ack  out  1  loader grant pulse
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address (pc word index)
if_ack  out  1  fetch grant pulse
if_rvalid  out  1  fetch read data valid pulse
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data access request
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_ack  out  1  data grant pulse
dm_rvalid  out  1  load data valid pulse
dm_rdata  out  DATA_W  load data
bram_en  out  1  BRAM enable
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM address
bram_wdata  out  DATA_W  BRAM write data
bram_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after the bram_en cycle
busy  out  1  grant issued this cycle or read in flight

Behaviour:
- Reset values: all ack and rvalid outputs 0; bram_en 0, bram_we 0; bram_addr 0, bram_wdata 0; if_rdata 0, dm_rdata 0; busy 0; starvation counter 0; tag pipeline cleared.
- Requester protocol:
  - A requester holds req and its operands stable until it sees ack.
  - It may drop req, or present a new request, in the cycle after ack.
- Arbitration:
  - Evaluated every cycle on the registered request view.
  - A requester whose ack is high in the current cycle is masked, so a held req is never granted twice.
- Priority: ld > dm > if.
  - Exception: when starve_cnt == STARVE_MAX and if_req is pending, if wins over dm. ld always wins.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle if_req=1 and fetch is not granted.
  - Clears to 0 on fetch grant or when if_req=0.
- Grant timing: winner selected in cycle N, registered outputs in cycle N+1.
  - bram_en=1 and the winner's ack=1, both one-cycle pulses.
  - bram_addr/bram_wdata/bram_we come from the winner.
  - Loader: bram_we=1 always. Fetch: bram_we=0. Data: bram_we=dm_we.
- Idle cycles: bram_en=0, bram_we=0; bram_addr/bram_wdata hold their last values.
- Read tracking:
  - A tag pipeline of depth RD_LAT records {none, IF, DM} for each issued cycle.
  - Loads and fetches push their tag. Writes push none.
- Read return:
  - When the tag exits the pipeline, bram_rdata is captured into if_rdata or dm_rdata.
  - The matching rvalid pulses one cycle later.
  - Read latency from ack to rvalid = RD_LAT+1 cycles, constant and independent of contention.
  - rdata holds its value until the next rvalid for that port.
- Ordering:
  - Accesses are issued in grant order, so a load granted after a store to the same address returns the stored data.
  - Back-to-back reads from alternating requesters return in issue order on their own ports, one per cycle.
- Throughput: one access per cycle sustained. Three simultaneous requests complete in three consecutive grant cycles (ld, dm, if), barring the starvation override.
- busy = bram_en | (any non-none tag in pipeline) | (rvalid pending capture).
  - The top-level controller does not leave LOAD mode while busy=1.
- Reset mid-operation: the tag pipeline flushes. No rvalid is emitted for reads issued before reset, and no ack is issued in the cycle after reset deasserts.
- Simultaneous events:
  - A new grant and a read return in the same cycle are both honoured.
  - An rvalid and an ack on the same port in the same cycle are legal.

Test Plan:
- Loader burst: ld_req held with addr 0..3 and data 0xA0..0xA3, advancing on each ack → four bram writes on consecutive-ack cycles; bram_we=1, bram_addr 0..3; ld_ack pulses 4 times; if/dm never acked.
- Single fetch with RD_LAT=2, BRAM preloaded with mem[5]=0x2402000A, if_req with if_addr=5 at cycle 0 → if_ack at cycle 1, if_rvalid at cycle 4, if_rdata=0x2402000A.
- Contention: ld, dm (load addr 7) and if (addr 3) all asserted at cycle 0 → grants in order ld, dm, if on cycles 1, 2, 3; dm_rvalid at cycle 5, if_rvalid at cycle 6; no double grant.
- Starvation: dm_req re-asserted every cycle for 20 cycles with if_req held → if_ack no later than cycle STARVE_MAX+2=10 after if_req rises; starve_cnt returns to 0 afterwards.
- Store-then-load: dm store 0x12345678 to addr 9, then dm load addr 9 → dm_rvalid with dm_rdata=0x12345678; no dm_rvalid for the store.
- Reset mid-read: if read granted, rstn=0 asserted one cycle later for 2 cycles → no if_rvalid ever appears; all outputs at reset values; busy=0 on the first cycle after reset releases.
